// File: rtl/rgmii_tx_if.sv
// rgmii_tx_if: byte-stream handshake feeding the RGMII transmit framer.
// Signals: txData payload byte, txDataValid/txDataLast qualifiers, txDataReady back-pressure.
interface rgmii_tx_if;
    logic [7:0] txData;
    logic       txDataValid;
    logic       txDataLast;
    logic       txDataReady;

    modport master (
        output txData,
        output txDataValid,
        output txDataLast,
        input  txDataReady
    );

    modport slave (
        input  txData,
        input  txDataValid,
        input  txDataLast,
        output txDataReady
    );
endinterface

// File: rtl/rgmii_tx.sv
// rgmii_tx: RGMII transmit framer. Wraps a byte stream in preamble/SFD, zero pad,
// optional CRC-32 FCS (macro RGMII_TX_FCS_EN) and an enforced inter-frame gap.
// Ports: txClkIn/rstIn clock and async active-high reset; mmcmLockedIn gates frame start;
// txIf slave byte stream; txData*/txCtrl* rise/fall pairs for external ODDRs;
// txUnderrunOut one-cycle abort pulse; txBusyOut high from frame start to end of IFG.
module rgmii_tx #(
    parameter int PREAMBLE_BYTES  = 7,
    parameter int MIN_FRAME_BYTES = 60,
    parameter int IFG_BYTES       = 12
) (
    input  logic       txClkIn,
    input  logic       rstIn,
    input  logic       mmcmLockedIn,
    rgmii_tx_if.slave  txIf,
    output logic [3:0] txDataRiseOut,
    output logic [3:0] txDataFallOut,
    output logic       txCtrlRiseOut,
    output logic       txCtrlFallOut,
    output logic       txUnderrunOut,
    output logic       txBusyOut
);

`ifdef RGMII_TX_FCS_EN
    typedef enum logic [2:0] {
        IDLE, PREAMBLE, PAYLOAD, PAD, FCS, DROP, IFG
    } state_t;
    localparam state_t TAIL = FCS;
`else
    typedef enum logic [2:0] {
        IDLE, PREAMBLE, PAYLOAD, PAD, DROP, IFG
    } state_t;
    localparam state_t TAIL = IFG;
`endif

    localparam logic [7:0]  PRE_CNT  = 8'(PREAMBLE_BYTES);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
    localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME_BYTES);

    state_t      state, stateNxt;
    logic [7:0]  cnt, cntNxt;
    logic [15:0] len, lenNxt, lenInc;
    logic [7:0]  dataQ, byteNxt;
    logic        enQ, erQ, underQ, busyQ;
    logic        enNxt, erNxt, underNxt;

    logic inValid;
    logic inLast;

    assign inValid = txIf.txDataValid;
    assign inLast  = txIf.txDataLast;

    // Ready rises once the SFD has been selected, i.e. while it is on the pins.
    assign txIf.txDataReady = (state == PAYLOAD) || (state == DROP);

    assign lenInc = (len == 16'hFFFF) ? len : len + 16'd1;

`ifdef RGMII_TX_FCS_EN
    logic [31:0] crc, crcNxt, fcsWord;

    assign fcsWord = ~crc;

    // Reflected CRC-32, one data bit per iteration, LSB first.
    function automatic logic [31:0] crcStep(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge txClkIn or posedge rstIn) begin
        if (rstIn) crc <= '1;
        else       crc <= crcNxt;
    end
`endif

    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        lenNxt   = len;
        byteNxt  = 8'h00;
        enNxt    = 1'b0;
        erNxt    = 1'b0;
        underNxt = 1'b0;
`ifdef RGMII_TX_FCS_EN
        crcNxt   = crc;
`endif
        unique case (state)
            IDLE: begin
                if (mmcmLockedIn && inValid) begin
                    stateNxt = PREAMBLE;
                    cntNxt   = '0;
                end
            end
            PREAMBLE: begin
                enNxt = 1'b1;
                if (cnt == PRE_CNT) begin
                    byteNxt  = 8'hD5;
                    stateNxt = PAYLOAD;
                    lenNxt   = '0;
`ifdef RGMII_TX_FCS_EN
                    crcNxt   = '1;
`endif
                end else begin
                    byteNxt = 8'h55;
                    cntNxt  = cnt + 8'd1;
                end
            end
            PAYLOAD: begin
                enNxt = 1'b1;
                if (inValid) begin
                    byteNxt = txIf.txData;
                    lenNxt  = lenInc;
`ifdef RGMII_TX_FCS_EN
                    crcNxt  = crcStep(crc, txIf.txData);
`endif
                    if (inLast) begin
                        stateNxt = (lenInc < MIN_LEN) ? PAD : TAIL;
                        cntNxt   = '0;
                    end
                end else begin
                    // Starved mid-frame: poison the frame with one error symbol.
                    erNxt    = 1'b1;
                    underNxt = 1'b1;
                    stateNxt = DROP;
                end
            end
            PAD: begin
                enNxt  = 1'b1;
                lenNxt = lenInc;
`ifdef RGMII_TX_FCS_EN
                crcNxt = crcStep(crc, 8'h00);
`endif
                if (lenInc >= MIN_LEN) begin
                    stateNxt = TAIL;
                    cntNxt   = '0;
                end
            end
`ifdef RGMII_TX_FCS_EN
            FCS: begin
                enNxt   = 1'b1;
                byteNxt = fcsWord[{cnt[1:0], 3'b000} +: 8];
                if (cnt == 8'd3) begin
                    stateNxt = IFG;
                    cntNxt   = '0;
                end else begin
                    cntNxt = cnt + 8'd1;
                end
            end
`endif
            DROP: begin
                if (inValid && inLast) begin
                    stateNxt = IFG;
                    cntNxt   = '0;
                end
            end
            IFG: begin
                if (cnt == IFG_LAST) begin
                    // Start straight from the last gap cycle so back-to-back
                    // frames see exactly IFG_BYTES idle symbols.
                    stateNxt = (mmcmLockedIn && inValid) ? PREAMBLE : IDLE;
                    cntNxt   = '0;
                end else begin
                    cntNxt = cnt + 8'd1;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge txClkIn or posedge rstIn) begin
        if (rstIn) begin
            state  <= IDLE;
            cnt    <= '0;
            len    <= '0;
            dataQ  <= '0;
            enQ    <= 1'b0;
            erQ    <= 1'b0;
            underQ <= 1'b0;
            busyQ  <= 1'b0;
        end else begin
            state  <= stateNxt;
            cnt    <= cntNxt;
            len    <= lenNxt;
            dataQ  <= byteNxt;
            enQ    <= enNxt;
            erQ    <= erNxt;
            underQ <= underNxt;
            busyQ  <= (state != IDLE);
        end
    end

    assign txDataRiseOut = dataQ[3:0];
    assign txDataFallOut = dataQ[7:4];
    assign txCtrlRiseOut = enQ;
    assign txCtrlFallOut = enQ ^ erQ;
    assign txUnderrunOut = underQ;
    assign txBusyOut     = busyQ;

endmodule
